// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding.
// Latches the decoded ID fields, detects load-use hazards, inserts bubbles on
// stall or flush, and resolves rs1/rs2 forwarding from EX/MEM and MEM/WB for
// the execute ALU.
module id_ex_operand_stage #(
    parameter int                 DATA_W = 32,
    parameter int                 RA_W   = 5,
    parameter int                 CTRL_W = 5,
    parameter logic [CTRL_W-1:0]  OPNULL = 5'h1F
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iPC,
    input  logic [DATA_W-1:0] iRs1Data,
    input  logic [DATA_W-1:0] iRs2Data,
    input  logic [DATA_W-1:0] iImm,
    input  logic [RA_W-1:0]   iRs1,
    input  logic [RA_W-1:0]   iRs2,
    input  logic [RA_W-1:0]   iRd,
    input  logic              iUsesRs1,
    input  logic              iUsesRs2,
    input  logic [CTRL_W-1:0] iALUControl,
    input  logic              iALUSrcB,
    input  logic              iRegWrite,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iFlush,
    input  logic              iExMemRegWrite,
    input  logic [RA_W-1:0]   iExMemRd,
    input  logic [DATA_W-1:0] iExMemResult,
    input  logic              iMemWbRegWrite,
    input  logic [RA_W-1:0]   iMemWbRd,
    input  logic [DATA_W-1:0] iMemWbResult,
    output logic              oStallID,
    output logic              oValid,
    output logic [DATA_W-1:0] oPC,
    output logic [DATA_W-1:0] oA,
    output logic [DATA_W-1:0] oB,
    output logic [CTRL_W-1:0] oALUControl,
    output logic [DATA_W-1:0] oStoreData,
    output logic [RA_W-1:0]   oRd,
    output logic              oRegWrite,
    output logic              oMemRead,
    output logic              oMemWrite,
    output logic [31:0]       oBubbleCount
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic              valid_d,     valid_q;
    logic [DATA_W-1:0] pc_d,        pc_q;
    logic [DATA_W-1:0] rs1_data_d,  rs1_data_q;
    logic [DATA_W-1:0] rs2_data_d,  rs2_data_q;
    logic [DATA_W-1:0] imm_d,       imm_q;
    logic [RA_W-1:0]   rs1_d,       rs1_q;
    logic [RA_W-1:0]   rs2_d,       rs2_q;
    logic [RA_W-1:0]   rd_d,        rd_q;
    logic [CTRL_W-1:0] alu_ctrl_d,  alu_ctrl_q;
    logic              alu_src_b_d, alu_src_b_q;
    logic              reg_write_d, reg_write_q;
    logic              mem_read_d,  mem_read_q;
    logic              mem_write_d, mem_write_q;
    logic [31:0]       bubble_cnt_d, bubble_cnt_q;

    logic              hazard_s;
    logic [DATA_W-1:0] rs2_fwd_s;

    // Select the youngest in-flight producer of a register; x0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [RA_W-1:0]   rs,
        input logic [DATA_W-1:0] reg_val,
        input logic              exmem_we,
        input logic [RA_W-1:0]   exmem_rd,
        input logic [DATA_W-1:0] exmem_val,
        input logic              memwb_we,
        input logic [RA_W-1:0]   memwb_rd,
        input logic [DATA_W-1:0] memwb_val
    );
        logic [DATA_W-1:0] res;
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs)) begin
            res = exmem_val;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs)) begin
            res = memwb_val;
        end else begin
            res = reg_val;
        end
        return res;
    endfunction

    // Load-use hazard: the load in EX produces a register the ID instruction reads.
    always_comb begin
        hazard_s = valid_q & mem_read_q & (rd_q != '0) & iValid &
                   ((iUsesRs1 & (iRs1 == rd_q)) | (iUsesRs2 & (iRs2 == rd_q)));
        oStallID = hazard_s & ~iFlush;
    end

    // Next-state: bubble on flush or hazard, otherwise capture the ID fields.
    always_comb begin
        valid_d      = iValid;
        pc_d         = iPC;
        rs1_data_d   = iRs1Data;
        rs2_data_d   = iRs2Data;
        imm_d        = iImm;
        rs1_d        = iRs1;
        rs2_d        = iRs2;
        rd_d         = iRd;
        alu_ctrl_d   = iALUControl;
        alu_src_b_d  = iALUSrcB;
        reg_write_d  = iRegWrite & iValid;
        mem_read_d   = iMemRead  & iValid;
        mem_write_d  = iMemWrite & iValid;
        bubble_cnt_d = bubble_cnt_q;
        if (iFlush || hazard_s) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            alu_ctrl_d  = OPNULL;
            alu_src_b_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else begin
            valid_d     = iValid;
        end
        // Only a real stall (not a flush) counts as a load-use bubble.
        if (!iFlush && hazard_s && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Pipeline register with synchronous reset taking priority over everything.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_ctrl_q   <= OPNULL;
            alu_src_b_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            bubble_cnt_q <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_b_q  <= alu_src_b_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Operand selection with forwarding on the registered source addresses.
    always_comb begin
        oA = fwd_sel(rs1_q, rs1_data_q, iExMemRegWrite, iExMemRd, iExMemResult,
                     iMemWbRegWrite, iMemWbRd, iMemWbResult);
        rs2_fwd_s = fwd_sel(rs2_q, rs2_data_q, iExMemRegWrite, iExMemRd, iExMemResult,
                            iMemWbRegWrite, iMemWbRd, iMemWbResult);
        if (alu_src_b_q) begin
            oB = imm_q;
        end else begin
            oB = rs2_fwd_s;
        end
        oStoreData = rs2_fwd_s;
    end

    assign oValid       = valid_q;
    assign oPC          = pc_q;
    assign oALUControl  = alu_ctrl_q;
    assign oRd          = rd_q;
    assign oRegWrite    = reg_write_q;
    assign oMemRead     = mem_read_q;
    assign oMemWrite    = mem_write_q;
    assign oBubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage: reset, capture, forwarding
// priority, load-use stall, flush during hazard, counter saturation.
module tb_id_ex_operand_stage;

    localparam logic [4:0] OPNULL = 5'h1F;
    localparam logic [4:0] OPADD  = 5'h01;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iValid;
    logic [31:0] iPC, iRs1Data, iRs2Data, iImm;
    logic [4:0]  iRs1, iRs2, iRd;
    logic        iUsesRs1, iUsesRs2;
    logic [4:0]  iALUControl;
    logic        iALUSrcB, iRegWrite, iMemRead, iMemWrite, iFlush;
    logic        iExMemRegWrite, iMemWbRegWrite;
    logic [4:0]  iExMemRd, iMemWbRd;
    logic [31:0] iExMemResult, iMemWbResult;
    logic        oStallID, oValid, oRegWrite, oMemRead, oMemWrite;
    logic [31:0] oPC, oA, oB, oStoreData, oBubbleCount;
    logic [4:0]  oALUControl, oRd;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_operand_stage dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iPC(iPC),
        .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm),
        .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd),
        .iUsesRs1(iUsesRs1), .iUsesRs2(iUsesRs2),
        .iALUControl(iALUControl), .iALUSrcB(iALUSrcB),
        .iRegWrite(iRegWrite), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iFlush(iFlush),
        .iExMemRegWrite(iExMemRegWrite), .iExMemRd(iExMemRd), .iExMemResult(iExMemResult),
        .iMemWbRegWrite(iMemWbRegWrite), .iMemWbRd(iMemWbRd), .iMemWbResult(iMemWbResult),
        .oStallID(oStallID), .oValid(oValid), .oPC(oPC), .oA(oA), .oB(oB),
        .oALUControl(oALUControl), .oStoreData(oStoreData), .oRd(oRd),
        .oRegWrite(oRegWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .oBubbleCount(oBubbleCount)
    );

    // Free-running clock, 10 time-unit period.
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one decoded instruction at the ID stage.
    task automatic id_instr(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2,
                            input logic u1, input logic u2, input logic [4:0] rd,
                            input logic srcb, input logic [31:0] imm,
                            input logic rw, input logic mr);
        iValid = v; iRs1 = rs1; iRs1Data = d1; iRs2 = rs2; iRs2Data = d2;
        iUsesRs1 = u1; iUsesRs2 = u2; iRd = rd; iALUSrcB = srcb; iImm = imm;
        iRegWrite = rw; iMemRead = mr; iMemWrite = 1'b0; iALUControl = OPADD;
        iPC = 32'h0000_1000;
    endtask

    task automatic fwd_set(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                           input logic ww, input logic [4:0] wr, input logic [31:0] wv);
        iExMemRegWrite = ew; iExMemRd = er; iExMemResult = ev;
        iMemWbRegWrite = ww; iMemWbRd = wr; iMemWbResult = wv;
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        iFlush = 1'b0;
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        // Reset for two cycles while ID holds a real ADD.
        iRST = 1'b1;
        id_instr(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 1'b1, 1'b1, 5'd3, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_ctrl", 32'(oALUControl), 32'(OPNULL));
        check("rst_a", oA, 32'd0);
        check("rst_b", oB, 32'd0);
        check("rst_cnt", oBubbleCount, 32'd0);
        check("rst_rd", 32'(oRd), 32'd0);
        iRST = 1'b0;

        // Plain capture of ADD x3 = x1(5) + x2(7).
        tick();
        check("cap_valid", 32'(oValid), 32'd1);
        check("cap_a", oA, 32'd5);
        check("cap_b", oB, 32'd7);
        check("cap_ctrl", 32'(oALUControl), 32'(OPADD));
        check("cap_rd", 32'(oRd), 32'd3);
        check("cap_rw", 32'(oRegWrite), 32'd1);
        check("cap_pc", oPC, 32'h0000_1000);

        // Forwarding priority on rs1 = x4 (raw value 0x99), immediate B.
        id_instr(1'b1, 5'd4, 32'h99, 5'd0, 32'd0, 1'b1, 1'b0, 5'd6, 1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        fwd_set(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        check("fwd_exmem", oA, 32'h11);
        check("fwd_imm_b", oB, 32'h40);
        iExMemRegWrite = 1'b0;
        #1;
        check("fwd_memwb", oA, 32'h22);
        fwd_set(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        #1;
        check("fwd_x0_raw", oA, 32'h99);

        // Invalid ID slot: decoded enables must not reach EX.
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        id_instr(1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 1'b1, 1'b1, 5'd9, 1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        check("inv_valid", 32'(oValid), 32'd0);
        check("inv_rw", 32'(oRegWrite), 32'd0);
        check("inv_mr", 32'(oMemRead), 32'd0);

        // Load-use: LW x5 in EX, then ADD x7 = x1 + x5.
        id_instr(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd4, 1'b1, 1'b1);
        tick();
        check("lw_mr", 32'(oMemRead), 32'd1);
        check("lw_rd", 32'(oRd), 32'd5);
        id_instr(1'b1, 5'd1, 32'd3, 5'd5, 32'hDEAD, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        check("lu_stall", 32'(oStallID), 32'd1);
        tick();
        check("lu_bub_valid", 32'(oValid), 32'd0);
        check("lu_bub_ctrl", 32'(oALUControl), 32'(OPNULL));
        check("lu_bub_rw", 32'(oRegWrite), 32'd0);
        check("lu_bub_rd", 32'(oRd), 32'd0);
        check("lu_cnt", oBubbleCount, 32'd1);
        check("lu_stall_gone", 32'(oStallID), 32'd0);
        fwd_set(1'b1, 5'd5, 32'hAB, 1'b0, 5'd0, 32'd0);
        tick();
        check("lu_add_valid", 32'(oValid), 32'd1);
        check("lu_add_a", oA, 32'd3);
        check("lu_add_b", oB, 32'hAB);
        check("lu_add_rd", 32'(oRd), 32'd7);
        check("lu_add_cnt", oBubbleCount, 32'd1);
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Immediate form with iRs2=5 but rs2 unused: no stall.
        id_instr(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd4, 1'b1, 1'b1);
        tick();
        id_instr(1'b1, 5'd1, 32'd3, 5'd5, 32'd0, 1'b1, 1'b0, 5'd8, 1'b1, 32'd12, 1'b1, 1'b0);
        #1;
        check("imm_nostall", 32'(oStallID), 32'd0);
        tick();
        check("imm_valid", 32'(oValid), 32'd1);
        check("imm_b", oB, 32'd12);
        check("imm_cnt", oBubbleCount, 32'd1);

        // Flush during a load-use hazard: bubble, counter untouched.
        id_instr(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd4, 1'b1, 1'b1);
        tick();
        id_instr(1'b1, 5'd1, 32'd3, 5'd5, 32'd0, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 1'b1, 1'b0);
        iFlush = 1'b1;
        #1;
        check("fl_stall", 32'(oStallID), 32'd0);
        tick();
        iFlush = 1'b0;
        check("fl_valid", 32'(oValid), 32'd0);
        check("fl_ctrl", 32'(oALUControl), 32'(OPNULL));
        check("fl_cnt", oBubbleCount, 32'd1);

        // Saturation: force the counter to all-ones across an idle edge.
        id_instr(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.bubble_cnt_q;
        #1;
        check("sat_preload", oBubbleCount, 32'hFFFF_FFFF);
        id_instr(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd4, 1'b1, 1'b1);
        tick();
        id_instr(1'b1, 5'd5, 32'd0, 5'd2, 32'd0, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        check("sat_stall", 32'(oStallID), 32'd1);
        tick();
        check("sat_cnt", oBubbleCount, 32'hFFFF_FFFF);
        check("sat_valid", 32'(oValid), 32'd0);

        // Reset in the middle of a stall: everything clears.
        id_instr(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd4, 1'b1, 1'b1);
        tick();
        id_instr(1'b1, 5'd5, 32'd0, 5'd2, 32'd0, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 1'b1, 1'b0);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        check("mrst_valid", 32'(oValid), 32'd0);
        check("mrst_cnt", oBubbleCount, 32'd0);
        check("mrst_mr", 32'(oMemRead), 32'd0);
        check("mrst_ctrl", 32'(oALUControl), 32'(OPNULL));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection; the direct upstream feeder of the execute ALU (drives its operand A, operand B and 5-bit control).
- Latches decoded ID fields each cycle, resolves forwarding from EX/MEM and MEM/WB, detects load-use hazards and handles branch flush.
- Inserts bubbles (ALU control = OPNULL, all write/memory enables low) when a stall or flush occurs.

Parameters:
- DATA_W, 32, datapath width
- RA_W, 5, register address width
- CTRL_W, 5, ALU control width (matches the ALU opcode encoding, including OPNULL)

Ports:
- iCLK in 1 clock, rising edge
- iRST in 1 synchronous active-high reset
- iValid in 1 ID holds a real instruction
- iPC in DATA_W PC of the ID instruction
- iRs1Data, iRs2Data in DATA_W register file read data
- iImm in DATA_W sign-extended immediate
- iRs1, iRs2, iRd in RA_W register addresses
- iUsesRs1, iUsesRs2 in 1 the instruction actually reads rs1/rs2
- iALUControl in CTRL_W ALU operation
- iALUSrcB in 1 0 selects the rs2 path, 1 selects the immediate
- iRegWrite, iMemRead, iMemWrite in 1 decoded control signals
- iFlush in 1 branch/jump taken in EX; squash
- iExMemRegWrite in 1, iExMemRd in RA_W, iExMemResult in DATA_W EX/MEM forward source
- iMemWbRegWrite in 1, iMemWbRd in RA_W, iMemWbResult in DATA_W MEM/WB forward source
- oStallID out 1 freeze PC and IF/ID this cycle
- oValid out 1 EX holds a real instruction
- oPC out DATA_W registered PC
- oA, oB out DATA_W ALU operands
- oALUControl out CTRL_W to the ALU
- oStoreData out DATA_W forwarded rs2 for stores
- oRd out RA_W; oRegWrite, oMemRead, oMemWrite out 1
- oBubbleCount out 32 count of load-use bubbles

Behaviour:
- Reset (iRST high at an edge): all registers cleared; oValid=0; oALUControl=OPNULL; oRd=0; all enables 0; oBubbleCount=0. Reset overrides flush, stall and capture, including mid-stall.
- Load-use (combinational): hazard = oValid & oMemRead & oRd!=0 & iValid & ((iUsesRs1 & iRs1==oRd) | (iUsesRs2 & iRs2==oRd)). oStallID = hazard & ~iFlush.
- Register update priority at each edge:
  - reset
  - iFlush: bubble
  - hazard: bubble and oBubbleCount+1, saturating at 0xFFFFFFFF
  - otherwise capture ID fields; oValid=iValid, and all enables are forced low when iValid=0
- Bubble: oValid=0; oALUControl=OPNULL; oRegWrite, oMemRead, oMemWrite=0; oRd=0.
- Latency: 1 cycle from ID capture to operands at the ALU. Forwarding is purely combinational on the registered rs1/rs2 (held internally).
- Forwarding for rs1 (rs2 identical):
  - EX/MEM match (iExMemRegWrite & iExMemRd!=0 & iExMemRd==rs1): use iExMemResult
  - else MEM/WB match under the same rule: use iMemWbResult
  - else the registered read data
  - EX/MEM wins over MEM/WB. x0 is never forwarded.
- oA = forwarded rs1. oB = iALUSrcB_reg ? imm_reg : forwarded rs2. oStoreData = forwarded rs2, always.
- No stall-induced duplicate: during a stall, ID presents the same instruction again next cycle and EX holds a bubble. The stalled instruction is captured once, after the load has moved to MEM.

Test Plan:
- Reset: assert iRST 2 cycles with iValid=1 inputs -> oValid=0, oALUControl=OPNULL, oA=oB=0, oBubbleCount=0.
- Plain capture: ADD rs1=x1(5), rs2=x2(7), rd=x3, no forwarding match -> next cycle oA=5, oB=7, oALUControl=OPADD, oRd=3, oRegWrite=1.
- Forward priority: EX holds rs1=x4; iExMemRd=4 with result 0x11, iMemWbRd=4 with result 0x22 -> oA=0x11. Drop iExMemRegWrite -> oA=0x22. Set rd=0 on both -> raw register value.
- Load-use: LW x5 in EX, ID ADD uses x5 as rs2 -> oStallID=1 for one cycle; next EX is a bubble; oBubbleCount=1. The ADD then enters EX with oB taken from iExMemResult. An immediate-form instruction (iUsesRs2=0, iRs2=5) -> no stall.
- Flush during hazard: same load-use with iFlush=1 -> oStallID=0, bubble inserted, oBubbleCount unchanged.
- Saturation: preload the counter via repeated hazards (or a forced value) of 0xFFFFFFFF, trigger a hazard -> stays 0xFFFFFFFF.
